// File: rtl/step_counter_if.sv
// Control/status bundle for step_counter: the master drives the controls,
// and the slave (the counter) returns count, ovf and tc.
interface step_counter_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
);
   logic              enable;
   logic              load;
   logic [WIDTH-1:0]  load_value;
   logic              up;
   logic [STEP_W-1:0] step;
   logic              sat_mode;
   logic [WIDTH-1:0]  terminal;
   logic [WIDTH-1:0]  count;
   logic              ovf;
   logic              tc;

   modport master (
      output enable, load, load_value, up, step, sat_mode, terminal,
      input  count, ovf, tc
   );

   modport slave (
      input  enable, load, load_value, up, step, sat_mode, terminal,
      output count, ovf, tc
   );
endinterface

// File: rtl/step_counter.sv
// Up/down counter with programmable step, parallel load and wrap/saturate.
// Optional STEP_COUNTER_STICKY_OVF_EN: ovf holds until load or reset.
module step_counter #(
   parameter int                 WIDTH       = 8,
   parameter int                 STEP_W      = 4,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
   input logic           clk,
   input logic           rst_b,
   step_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             tc_q, tc_d;
   logic [WIDTH:0]   step_x;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   always_comb begin
      step_x = {{(WIDTH + 1 - STEP_W){1'b0}}, bus.step};
      sum    = {1'b0, count_q} + step_x;
      diff   = {1'b0, count_q} - step_x;

      count_d = count_q;
`ifdef STEP_COUNTER_STICKY_OVF_EN
      ovf_d = ovf_q;
`else
      ovf_d = 1'b0;
`endif

      if (bus.load) begin
         count_d = bus.load_value;
         ovf_d   = 1'b0;
      end else if (bus.enable) begin
         if (bus.up) begin
            // bit WIDTH of the sum is the carry out
            if (sum[WIDTH]) begin
               ovf_d   = 1'b1;
               count_d = bus.sat_mode ? MAX : sum[WIDTH-1:0];
            end else begin
               count_d = sum[WIDTH-1:0];
            end
         end else begin
            if (diff[WIDTH]) begin
               ovf_d   = 1'b1;
               count_d = bus.sat_mode ? '0 : diff[WIDTH-1:0];
            end else begin
               count_d = diff[WIDTH-1:0];
            end
         end
      end

      // compare the next count so tc lines up with the count it describes
      tc_d = (count_d == bus.terminal);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= RESET_VALUE;
         ovf_q   <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         tc_q    <= tc_d;
      end
   end

   assign bus.count = count_q;
   assign bus.ovf   = ovf_q;
   assign bus.tc    = tc_q;

endmodule

// File: doc/step_counter.md
Name: step_counter

Overview:
- Parametrised up/down counter with programmable step, parallel load and wrap or saturate mode.
- Generalises the single-increment register used in the divider datapath: iteration counters, address generators and bit-index trackers.
- Registered count plus registered overflow and terminal-count flags.
- Built from the team's adder and register primitives or equivalent RTL.

Parameters:
- WIDTH, 8, count width in bits (>= 2).
- STEP_W, 4, width of the step input (1 <= STEP_W <= WIDTH).
- RESET_VALUE, 0, count value after reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_b  input  1  asynchronous active-low reset.
- enable  input  1  advance count by step this cycle.
- load  input  1  parallel load of load_value; has priority over enable.
- load_value  input  WIDTH  value taken on load.
- up  input  1  direction: 1 = count up, 0 = count down.
- step  input  STEP_W  unsigned step magnitude, zero-extended to WIDTH.
- sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo 2^WIDTH.
- terminal  input  WIDTH  terminal-count compare value.
- count  output  WIDTH  registered count.
- ovf  output  1  registered pulse: last update crossed a bound.
- tc  output  1  registered: count == terminal.

Behaviour:
- Interface: one clock (clk); reset rst_b is asynchronous and active-low.
- Reset (rst_b = 0, any time, including mid-operation), asynchronously:
  - count = RESET_VALUE, ovf = 0.
  - tc = (RESET_VALUE == terminal), re-evaluated once reset is released.
- Per rising edge, priority load > enable > hold:
  - load = 1: count <= load_value; ovf <= 0. enable, up, step and sat_mode are ignored.
  - enable = 1, load = 0:
    - up = 1: compute count + step at WIDTH+1 bits; overflow when the carry out is set.
    - up = 0: compute count - step; underflow when the borrow is set.
    - On overflow or underflow: ovf <= 1.
      - sat_mode = 0: count <= low WIDTH bits (wrap).
      - sat_mode = 1: count <= all-ones (up) or 0 (down).
    - Otherwise: count <= result; ovf <= 0.
  - enable = 0, load = 0: count holds; ovf <= 0.
- ovf is a one-cycle pulse aligned with the count update that caused it.
- step = 0 with enable = 1: count unchanged, ovf = 0.
- Landing exactly on a bound is not an overflow:
  - count = max - step, up: result = all-ones, ovf = 0.
  - count = step, down: result = 0, ovf = 0.
- Saturated counter at max with up and step > 0: stays at max, ovf = 1 on every enabled cycle.
- tc is a registered compare of the next count against terminal: it is valid in the same cycle as the count it describes. A change on terminal alone is reflected at the next edge.
- Latency: one cycle from enable/load to count, ovf and tc.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: STEP_COUNTER_STICKY_OVF_EN.
- Defined:
  - ovf becomes sticky: it sets on any overflow or underflow and holds.
  - Cleared only by load = 1 or reset.
  - Overflow and load in the same cycle: load wins, ovf = 0.
- Undefined: ovf is the one-cycle pulse described above.

Test Plan:
- Reset mid-count: count = 0x37, assert rst_b = 0 asynchronously between edges -> count = RESET_VALUE (0x00) and ovf = 0 immediately; tc = 1 once terminal = 0x00.
- Wrap up: WIDTH = 8, load 0xFE, up = 1, step = 3, sat_mode = 0, one enable -> count = 0x01, ovf = 1 for one cycle; next enable -> count = 0x04, ovf = 0.
- Saturate down: load 0x02, up = 0, step = 5, sat_mode = 1 -> count = 0x00, ovf = 1; repeat enable -> count stays 0x00, ovf = 1.
- Exact bound: load 0xFB, up = 1, step = 4 -> count = 0xFF, ovf = 0. Step 0 with enable -> count unchanged, ovf = 0.
- Load priority and tc: terminal = 0x10; load = 1 and enable = 1 with load_value = 0x10 -> count = 0x10, tc = 1 in the same cycle. Then one enable with step = 1 up -> count = 0x11, tc = 0.
- Sticky (macro defined): wrap event -> ovf = 1 and holds over 5 idle cycles; load 0x00 -> ovf = 0.
